// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } state_t;

  typedef enum logic {
    GRANT_IF = 1'b0,
    GRANT_D  = 1'b1
  } grant_t;

  localparam int TIMEOUT_DEF = 16;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker: on contention the side not granted last time wins.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant,
  output logic       any
);

  assign any = |req;
  // req[0] = fetch, req[1] = data; grant is 1 for data
  assign grant = (&req) ? ~last : req[1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data load/store,
// with round-robin arbitration and a per-transaction watchdog.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              cpu_stall,
  output logic              timeout_err
);

  state_t     state, state_nxt;
  grant_t     last_grant;
  logic [7:0] cnt;
  logic       grant, any_req, expire, finish;

  rr_arbiter2 u_rr (
    .req   ({d_req, if_req}),
    .last  (last_grant),
    .grant (grant),
    .any   (any_req)
  );

  assign expire    = (cnt == 8'(TIMEOUT - 1));
  assign finish    = mem_ready | expire;
  assign cpu_stall = (if_req & ~if_ack) | (d_req & ~d_ack);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:           if (any_req) state_nxt = grant_t'(grant) == GRANT_D ? BUSY_D : BUSY_IF;
      BUSY_IF, BUSY_D: if (finish) state_nxt = IDLE;
      default:        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant  <= GRANT_D;
      cnt         <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_be      <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      if_rdata    <= '0;
      d_rdata     <= '0;
      if_ack      <= 1'b0;
      d_ack       <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            mem_req    <= 1'b1;
            cnt        <= '0;
            last_grant <= grant_t'(grant);
            if (grant_t'(grant) == GRANT_D) begin
              mem_addr  <= d_addr;
              mem_we    <= d_we;
              mem_be    <= d_be;
              mem_wdata <= d_wdata;
            end else begin
              mem_addr <= if_addr;
              mem_we   <= 1'b0;
              mem_be   <= 4'hF;
            end
          end
        end
        BUSY_IF, BUSY_D: begin
          if (finish) begin
            mem_req <= 1'b0;
            // an aborted transaction still acks, but with zero data
            if (state == BUSY_IF) begin
              if_ack   <= 1'b1;
              if_rdata <= mem_ready ? mem_rdata : '0;
            end else begin
              d_ack   <= 1'b1;
              d_rdata <= mem_ready ? mem_rdata : '0;
            end
            if (!mem_ready) timeout_err <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench: the bench plays both requesters and the memory, and a
// transaction-level model predicts grants, ack timing, data and the error flag.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int TO = 16;

  logic        clk, rst_n;
  logic        if_req, if_ack, d_req, d_we, d_ack;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be, mem_be;
  logic        mem_req, mem_we, mem_ready, cpu_stall, timeout_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .cpu_stall(cpu_stall), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Model: one outstanding transaction record plus the round-robin memory of who went last.
  bit        m_busy, m_is_d, m_we, m_last;
  bit [31:0] m_addr, m_wdata;
  bit [3:0]  m_be;
  int        m_wait, m_lat, next_lat;
  bit        e_if_ack, e_d_ack, e_terr;
  bit [31:0] e_if_rdata, e_d_rdata;
  bit [31:0] mem_arr [4];
  bit        quiet;

  function automatic bit [31:0] merge(bit [31:0] old, bit [31:0] wd, bit [3:0] be);
    bit [31:0] r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = wd[i*8 +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_last = 1; m_wait = 0;
    e_if_ack = 0; e_d_ack = 0; e_terr = 0; e_if_rdata = 0; e_d_rdata = 0;
  endtask

  task automatic complete(input bit [31:0] data, input bit aborted);
    if (m_is_d) begin e_d_ack = 1; e_d_rdata = data; end
    else        begin e_if_ack = 1; e_if_rdata = data; end
    if (aborted) e_terr = 1;
    m_busy = 0;
  endtask

  // The bench memory answers after m_lat not-ready busy cycles; ready is noise when idle.
  task automatic drive_mem();
    mem_ready = m_busy ? (m_wait == m_lat) : 1'($urandom_range(0, 1));
    mem_rdata = (m_busy && m_is_d && !m_we) ? mem_arr[m_addr[3:2]] : $urandom;
  endtask

  // What the next rising edge should do, given the inputs now driven.
  task automatic model_edge();
    e_if_ack = 0; e_d_ack = 0;
    if (!m_busy) begin
      if (if_req || d_req) begin
        m_is_d = d_req && (!if_req || !m_last);
        if (m_is_d) begin
          m_addr = d_addr; m_we = d_we; m_be = d_be; m_wdata = d_wdata;
        end else begin
          m_addr = if_addr; m_we = 0; m_be = 4'hF;
        end
        m_last = m_is_d; m_busy = 1; m_wait = 0; m_lat = next_lat;
      end
    end else if (mem_ready) begin
      if (m_is_d && m_we) mem_arr[m_addr[3:2]] = merge(mem_arr[m_addr[3:2]], m_wdata, m_be);
      complete(mem_rdata, 0);
    end else if (m_wait == TO - 1) begin
      complete(32'h0, 1);
    end else begin
      m_wait++;
    end
  endtask

  task automatic check_outputs();
    chk("mem_req", mem_req, m_busy);
    if (m_busy) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_we", mem_we, m_we);
      chk("mem_be", mem_be, m_be);
      if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
    end
    chk("if_ack", if_ack, e_if_ack);
    chk("d_ack", d_ack, e_d_ack);
    chk("if_rdata", if_rdata, e_if_rdata);
    chk("d_rdata", d_rdata, e_d_rdata);
    chk("timeout_err", timeout_err, e_terr);
    chk("cpu_stall", cpu_stall, (if_req & ~e_if_ack) | (d_req & ~e_d_ack));
  endtask

  task automatic step();
    drive_mem();
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic new_fetch();
    if_req = 1; if_addr = $urandom & 32'hFFFF_FFFC;
  endtask

  task automatic new_data();
    d_req = 1; d_we = 1'($urandom_range(0, 1)); d_be = 4'($urandom);
    d_addr = 32'h1001_0000 + 32'($urandom_range(0, 3)) * 4; d_wdata = $urandom;
  endtask

  task automatic drive_reqs();
    if (if_req) begin
      if (e_if_ack) begin
        if (!quiet && $urandom_range(0, 3) == 0) new_fetch(); else if_req = 0;
      end
    end else if (!quiet && $urandom_range(0, 2) == 0) new_fetch();
    if (d_req) begin
      if (e_d_ack) begin
        if (!quiet && $urandom_range(0, 3) == 0) new_data(); else d_req = 0;
      end
    end else if (!quiet && $urandom_range(0, 2) == 0) new_data();
    next_lat = ($urandom_range(0, 7) == 0) ? 1000 : $urandom_range(0, 3);
  endtask

  initial begin
    rst_n = 0; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_be = 0;
    d_addr = 0; d_wdata = 0; mem_ready = 0; mem_rdata = 0; quiet = 0;
    for (int i = 0; i < 4; i++) mem_arr[i] = $urandom;
    model_reset();
    @(negedge clk); @(negedge clk);
    check_outputs();
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    rst_n = 1;

    for (int c = 0; c < 3000; c++) begin
      quiet = (c >= 2960);
      drive_reqs();
      step();
    end

    // Directed load that never sees mem_ready: aborts after TO busy cycles.
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h1001_0000; next_lat = 1000;
    for (int i = 0; i < TO + 3; i++) begin
      step();
      if (e_d_ack) d_req = 0;
    end
    chk("timeout_sticky", timeout_err, 1);

    // Reset while a store is in flight drops it without an ack.
    d_req = 1; d_we = 1; d_be = 4'b0011; d_wdata = 32'h0000_BEEF;
    step(); step();
    chk("busy_before_rst", mem_req, 1);
    rst_n = 0;
    @(negedge clk);
    model_reset();
    check_outputs();
    chk("rst_terr_clear", timeout_err, 0);

    // After release with both requesting, fetch is granted first.
    rst_n = 1; if_req = 1; if_addr = 32'h0040_0000; next_lat = 0;
    step();
    chk("first_grant_if", mem_addr, 32'h0040_0000);
    step();
    if_req = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (e_d_ack) d_req = 0;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
